mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto a single synchronous memory with starvation guard
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ready,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [2:0]  dm_funct3,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_ready,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        write_mem,
    output logic [2:0]  funct3,
    output logic [31:0] write_address,
    output logic [31:0] write_data,
    output logic [31:0] read_address,
    input  logic [31:0] read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic        own_q;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] ra_q, wa_q, wd_q, if_rdata_q, dm_rdata_q;
    logic        fetch_win, hs;
    // Arbitration, next state, starvation counter and memory-side outputs
    always_comb begin
        fetch_win     = if_req && (!dm_req || starve_q == 4'(STARVE_LIMIT));
        if_ready      = state_q == IDLE && !rst && fetch_win;
        dm_ready      = state_q == IDLE && !rst && dm_req && !fetch_win;
        hs            = if_ready || dm_ready;
        state_d       = state_q == IDLE ? (hs ? ACCESS : IDLE) : state_q == ACCESS ? RESP : IDLE;
        starve_d      = state_q != IDLE ? starve_q :
                        (if_ready || !if_req) ? 4'd0 :
                        (starve_q < 4'(STARVE_LIMIT)) ? starve_q + 4'd1 : starve_q;
        write_mem     = state_q == ACCESS && we_q && !rst;
        funct3        = state_q == ACCESS ? f3_q : 3'b010;
        if_rvalid     = state_q == RESP && !own_q && !we_q && !rst;
        dm_rvalid     = state_q == RESP && own_q && !we_q && !rst;
        if_rdata      = if_rvalid ? read_data : if_rdata_q;
        dm_rdata      = dm_rvalid ? read_data : dm_rdata_q;
        read_address  = ra_q;
        write_address = wa_q;
        write_data    = wd_q;
    end
    // State register and starvation counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
    // Capture winner's request; address/data registers hold their last driven values
    always_ff @(posedge clk) begin
        if (rst) begin
            own_q      <= 1'b0;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            ra_q       <= 32'd0;
            wa_q       <= 32'd0;
            wd_q       <= 32'd0;
            if_rdata_q <= 32'd0;
            dm_rdata_q <= 32'd0;
        end else begin
            if (hs) begin
                own_q <= dm_ready;
                we_q  <= dm_ready && dm_we;
                f3_q  <= dm_ready ? dm_funct3 : 3'b010;
                if (dm_ready && dm_we) begin
                    wa_q <= dm_addr;
                    wd_q <= dm_wdata;
                end else begin
                    ra_q <= dm_ready ? dm_addr : if_addr;
                end
            end
            if (if_rvalid) if_rdata_q <= read_data;
            if (dm_rvalid) dm_rdata_q <= read_data;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk, rst;
    logic        if_req, if_ready, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_ready, dm_rvalid;
    logic [2:0]  dm_funct3, funct3;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic        write_mem;
    logic [31:0] write_address, write_data, read_address, read_data;
    int          checks = 0;
    int          errors = 0;
    logic [9:0]  pat;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .write_mem(write_mem), .funct3(funct3), .write_address(write_address),
        .write_data(write_data), .read_address(read_address), .read_data(read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0;
        dm_funct3 = 0; dm_addr = 0; dm_wdata = 0; read_data = 0;
        cyc; cyc;
        if_req = 1; #1;
        chk("rst_ready_low", if_ready, 1'b0);
        if_req = 0; rst = 0; #1;
        chk("rst_write_mem", write_mem, 1'b0);
        chk("rst_funct3", funct3, 3'b010);
        chk("rst_read_addr", read_address, 32'h0);
        chk("rst_write_addr", write_address, 32'h0);
        chk("rst_write_data", write_data, 32'h0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        chk("rst_rvalids", {if_rvalid, dm_rvalid}, 2'b00);
        chk("rst_idle_no_ready", {if_ready, dm_ready}, 2'b00);

        // fetch only
        if_req = 1; if_addr = 32'h10; #1;
        chk("fetch_ready", {if_ready, dm_ready}, 2'b10);
        cyc; if_req = 0; #1;
        chk("fetch_read_addr", read_address, 32'h10);
        chk("fetch_busy_ready", if_ready, 1'b0);
        chk("fetch_write_mem", write_mem, 1'b0);
        read_data = 32'h00500093;
        cyc; #1;
        chk("fetch_rvalid", {if_rvalid, dm_rvalid}, 2'b10);
        chk("fetch_rdata", if_rdata, 32'h00500093);
        cyc; read_data = 32'h0; #1;
        chk("fetch_rvalid_drop", if_rvalid, 1'b0);
        chk("fetch_rdata_hold", if_rdata, 32'h00500093);
        chk("fetch_raddr_hold", read_address, 32'h10);

        // store
        dm_req = 1; dm_we = 1; dm_funct3 = 3'b010; dm_addr = 32'h200; dm_wdata = 32'hDEADBEEF; #1;
        chk("store_ready", {if_ready, dm_ready}, 2'b01);
        cyc; dm_req = 0; #1;
        chk("store_write_mem", write_mem, 1'b1);
        chk("store_waddr", write_address, 32'h200);
        chk("store_wdata", write_data, 32'hDEADBEEF);
        cyc; #1;
        chk("store_resp_wm", write_mem, 1'b0);
        chk("store_no_rvalid", dm_rvalid, 1'b0);
        cyc; #1;
        chk("store_idle_wm", write_mem, 1'b0);
        chk("store_waddr_hold", write_address, 32'h200);

        // load byte
        dm_req = 1; dm_we = 0; dm_funct3 = 3'b000; dm_addr = 32'h3; #1;
        chk("lb_ready", dm_ready, 1'b1);
        chk("lb_idle_f3", funct3, 3'b010);
        cyc; dm_req = 0; #1;
        chk("lb_access_f3", funct3, 3'b000);
        chk("lb_raddr", read_address, 32'h3);
        chk("lb_write_mem", write_mem, 1'b0);
        read_data = 32'hAB;
        cyc; #1;
        chk("lb_resp_f3", funct3, 3'b010);
        chk("lb_rvalid", {if_rvalid, dm_rvalid}, 2'b01);
        chk("lb_rdata", dm_rdata, 32'hAB);
        cyc;

        // contention
        pat = 10'b0111101111;
        if_req = 1; if_addr = 32'h40;
        dm_req = 1; dm_we = 0; dm_funct3 = 3'b010; dm_addr = 32'h100;
        for (int g = 0; g < 10; g++) begin
            #1;
            chk($sformatf("cont_grant%0d", g), {if_ready, dm_ready}, pat[g] ? 2'b01 : 2'b10);
            cyc; #1;
            chk($sformatf("cont_busy%0d", g), {if_ready, dm_ready}, 2'b00);
            chk($sformatf("cont_raddr%0d", g), read_address, pat[g] ? 32'h100 : 32'h40);
            cyc; cyc;
        end
        if_req = 0; dm_req = 0; #1;
        chk("cont_idle_none", {if_ready, dm_ready}, 2'b00);
        cyc;

        // reset during store ACCESS
        dm_req = 1; dm_we = 1; dm_addr = 32'h300; dm_wdata = 32'h12345678; #1;
        chk("rmid_ready", dm_ready, 1'b1);
        cyc; dm_req = 0; #1;
        chk("rmid_wm_before", write_mem, 1'b1);
        rst = 1;
        cyc; rst = 0; #1;
        chk("rmid_wm_after", write_mem, 1'b0);
        chk("rmid_no_rvalid", {if_rvalid, dm_rvalid}, 2'b00);
        chk("rmid_waddr_clr", write_address, 32'h0);
        chk("rmid_dm_rdata_clr", dm_rdata, 32'h0);

        // back-to-back with fields changing after accept
        dm_req = 1; dm_we = 0; dm_funct3 = 3'b010; dm_addr = 32'h400; #1;
        chk("rmid_accept_next", dm_ready, 1'b1);
        cyc; dm_addr = 32'h500; dm_funct3 = 3'b001; #1;
        chk("b2b_access_ready", dm_ready, 1'b0);
        chk("b2b_raddr1", read_address, 32'h400);
        chk("b2b_f3_1", funct3, 3'b010);
        cyc; read_data = 32'h55; #1;
        chk("b2b_resp_ready", dm_ready, 1'b0);
        chk("b2b_rvalid", dm_rvalid, 1'b1);
        chk("b2b_rdata", dm_rdata, 32'h55);
        cyc; #1;
        chk("b2b_second_ready", dm_ready, 1'b1);
        cyc; dm_req = 0; #1;
        chk("b2b_raddr2", read_address, 32'h500);
        chk("b2b_f3_2", funct3, 3'b001);
        cyc; cyc;

        // top-of-memory address
        if_req = 1; if_addr = 32'hFFFF_FFFC; #1;
        chk("top_ready", if_ready, 1'b1);
        cyc; if_req = 0; #1;
        chk("top_raddr", read_address, 32'hFFFF_FFFC);
        read_data = 32'hCAFEF00D;
        cyc; #1;
        chk("top_rdata", if_rdata, 32'hCAFEF00D);
        cyc;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
